// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// controller state type and a small decode helper.
package muldiv_pkg;

    // RISC-V M-extension funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // True for the signed divide/remainder operations
    function automatic logic is_signed_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned radix-2 restoring divider. One quotient bit per cycle, fixed
// XLEN-cycle latency from the start pulse. Results stay in the registers
// after completion until the next start.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_busy,
    output logic            o_last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;   // holds remaining dividend bits, fills with quotient bits
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    // Trial subtraction of the divisor from the partial remainder with the next dividend bit shifted in
    always_comb begin
        w_shift = {r_rem, r_quo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_div};
    end

    // Iteration registers: load on start, one restoring step per cycle while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= CW'(XLEN-1);
            r_busy <= 1'b1;
        end else if (i_kill) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            if (!w_diff[XLEN]) begin
                r_rem <= w_diff[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_busy      = r_busy;
    assign o_last      = r_busy && (r_cnt == '0);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit. Multiplies finish in one working cycle, divides
// run through the iterative core followed by a sign-fix cycle, and divide
// special cases (zero divisor, signed overflow) resolve in the accept cycle.
// result_valid is registered one cycle after the controller enters DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e           r_state;
    state_e           w_state_next;
    logic [2:0]       r_op;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_result;
    logic             r_result_valid;

    logic             w_accept;
    logic             w_signed;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_special_result;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div_start;

    logic             w_a_sgn;
    logic             w_b_sgn;
    logic [XLEN:0]    w_a_ext;
    logic [XLEN:0]    w_b_ext;
    logic [2*XLEN-1:0] w_a_wide;
    logic [2*XLEN-1:0] w_b_wide;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]  w_mul_result;

    logic [XLEN-1:0]  w_quo;
    logic [XLEN-1:0]  w_rem;
    logic             w_div_busy;
    logic             w_div_last;
    logic [XLEN-1:0]  w_fix_result;

    assign start_ready = (r_state == ST_IDLE);
    assign w_accept    = start_valid && start_ready && !flush;

    // Decode of the incoming request: divide special cases and operand magnitudes
    always_comb begin
        w_signed   = is_signed_div(op);
        w_div_zero = (operand_b == '0);
        w_ovf      = w_signed && (operand_a == INT_MIN) && (operand_b == '1);
        w_special  = op[2] && (w_div_zero || w_ovf);
        if (w_div_zero) begin
            w_special_result = op[1] ? operand_a : '1;
        end else begin
            w_special_result = op[1] ? '0 : operand_a;
        end
        w_abs_a     = (w_signed && operand_a[XLEN-1]) ? (~operand_a + 1'b1) : operand_a;
        w_abs_b     = (w_signed && operand_b[XLEN-1]) ? (~operand_b + 1'b1) : operand_b;
        w_div_start = w_accept && op[2] && !w_special;
    end

    // Multiply: (XLEN+1)-bit sign/zero extension, then a 2*XLEN product; only the low 2*XLEN bits matter
    always_comb begin
        w_a_sgn      = (r_op[1:0] != 2'b11);
        w_b_sgn      = (r_op[1:0] == 2'b01);
        w_a_ext      = {w_a_sgn & r_a[XLEN-1], r_a};
        w_b_ext      = {w_b_sgn & r_b[XLEN-1], r_b};
        w_a_wide     = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
        w_b_wide     = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
        w_prod       = w_a_wide * w_b_wide;
        w_mul_result = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    muldiv_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_start),
        .i_kill      (flush),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_busy      (w_div_busy),
        .o_last      (w_div_last)
    );

    // Sign correction of the unsigned divider outputs
    always_comb begin
        if (r_op[1]) begin
            w_fix_result = r_neg_r ? (~w_rem + 1'b1) : w_rem;
        end else begin
            w_fix_result = r_neg_q ? (~w_quo + 1'b1) : w_quo;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!op[2])         w_state_next = ST_MUL;
                    else if (w_special) w_state_next = ST_DONE;
                    else                w_state_next = ST_DIV;
                end
            end
            ST_MUL:  w_state_next = ST_DONE;
            ST_DIV:  if (w_div_last) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            ST_DONE: if (r_result_valid && result_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
    end

    // State, captured request and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_tag          <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= op;
                r_a     <= operand_a;
                r_b     <= operand_b;
                r_tag   <= in_tag;
                r_neg_q <= w_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                r_neg_r <= w_signed && operand_a[XLEN-1];
            end
            if (w_accept && w_special) begin
                r_result <= w_special_result;
            end else if (r_state == ST_MUL) begin
                r_result <= w_mul_result;
            end else if (r_state == ST_FIX) begin
                r_result <= w_fix_result;
            end
            r_result_valid <= !flush && (r_state == ST_DONE) && !(r_result_valid && result_ready);
        end
    end

    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign out_tag      = r_tag;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and executes all eight M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The pipeline stalls on a valid/ready handshake while a result is pending. Multiplies take a fixed short latency; divides use an iterative radix-2 restoring divider.

## Interface
- XLEN, 32, operand/result width (≥8, even)
- TAG_W, 5, width of opaque tag (destination register) carried with the operation
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of in-flight operation
- start_valid  in  1  operation request
- start_ready  out  1  unit can accept (high only in IDLE)
- op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- in_tag  in  TAG_W  tag captured on accept
- result_valid  out  1  result available
- result_ready  in  1  consumer takes result
- result  out  XLEN  operation result
- out_tag  out  TAG_W  tag of the result

## Operation
- Accept occurs when start_valid && start_ready && !flush. On accept, op, operands and tag are registered.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE → MUL on an accepted op[2]=0.
- IDLE → DIV on an accepted op[2]=1 that is not a special case.
- IDLE → DONE on an accepted special case; the result is computed in the accept cycle.
- MUL → DONE.
- DIV → FIX after XLEN iterations.
- FIX → DONE.
- DONE → IDLE when result_ready.
- MUL state: forms a 2·XLEN product with (XLEN+1)-bit sign extension.
  - MUL takes the low half.
  - MULH treats both operands as signed and takes the high half.
  - MULHSU treats a as signed and b as unsigned, and takes the high half.
  - MULHU treats both operands as unsigned and takes the high half.
- DIV state:
  - Signed ops divide magnitudes.
  - Each cycle shifts in one dividend bit and does a trial subtraction; the iteration counter runs XLEN-1 down to 0.
  - FIX applies the signs: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- Special cases, no iteration:
  - Divide by zero: quotient is all ones (DIV/DIVU); remainder is operand_a (REM/REMU).
  - Signed overflow, a = −2^(XLEN−1) and b = −1: DIV returns a; REM returns 0.
- result, out_tag and result_valid are registered and held stable in DONE until result_ready.
- flush in any state: next state IDLE, result_valid low next cycle, result discarded. flush wins over a same-cycle accept or result_ready.
- Reset, asynchronous at any time including mid-divide:
  - State goes to IDLE.
  - result_valid=0, result=0, out_tag=0, start_ready=1.
  - The iteration counter and datapath registers are cleared.

## Timing
- Accept at edge E0. result_valid is high from E_n onward, where:
  - special-case div: n=1
  - multiply: n=2
  - normal divide: n=XLEN+2 (34 for XLEN=32)
- start_ready is combinational from state (IDLE only). There is no accept while DONE, even with result_ready high, so there is a minimum one-cycle bubble between operations.
- Latency is data-independent: no early termination.
- Single outstanding operation.

## Structure
- Package muldiv_pkg holds:
  - the op encoding localparams (OP_MUL…OP_REMU)
  - the state enum
  - helper function is_signed_div(op)
- Sub-module muldiv_div_core: the unsigned iterative restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, busy.
  - Parametrised by XLEN.
- Sign handling, multiply, special cases and the FSM stay in the top module.

## Test plan
- MULH/MULHSU/MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF → results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively; MUL → 0x00000001. result_valid 2 cycles after accept.
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. result_valid at cycle 34, tag preserved.
- DIVU/REMU b=0, a=0x1234 → 0xFFFFFFFF and 0x1234. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM → 0. result_valid after 1 cycle.
- result_ready held low 10 cycles in DONE → result and out_tag stable, start_ready low, a new start_valid is ignored. Raise result_ready → IDLE next cycle.
- flush asserted at iteration 15 of a DIV → result_valid never rises, unit in IDLE next cycle. A subsequent DIVU 100/7 returns 14 with correct timing.
- rst_n pulsed low asynchronously mid-divide → outputs go to reset values immediately. Run a randomized 10k-op comparison against a reference model for XLEN=32 and XLEN=16.
